// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } t_fetch_state;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one read at a time, hands raw words to decode.
// Latency: REQ -> WAIT -> HOLD, one word per 3 cycles at best with 1-cycle memory.
// Backpressure: dec_ready_i=0 parks the word in HOLD; mem_req_o is held until mem_gnt_i.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   en_i                         fetch enable (current word finishes before idling)
//   mem_req_o/addr_o/gnt_i       single-outstanding read request channel
//   mem_rvalid_i/rdata_i         read response, one cycle, raw byte order
//   dec_ready_i/rd_en_o/data_o/pc_o  decoder hand-off
//   redirect_i/redirect_pc_i     branch/jump target load, squashes in-flight work
//   fault_o                      sticky misaligned-redirect flag
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect raises fault_o and stops
// fetching until reset). Without it, fault_o is 0 and the target's low two bits are cleared.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [INSTR_W-1:0]  mem_rdata_i,
  input  logic                dec_ready_i,
  output logic                dec_rd_en_o,
  output logic [INSTR_W-1:0]  dec_data_o,
  output logic [ADDR_W-1:0]   dec_pc_o,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  output logic                fault_o
);

  t_fetch_state         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]    dpc_q, dpc_d;
  logic                 fault_q, fault_d;
  logic                 req_raw, rd_en_raw;

  logic                 misalign;
  logic [ADDR_W-1:0]    redirect_tgt;
  logic                 en_eff;

`ifdef FETCH_ALIGN_CHK_EN
  assign misalign     = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc_i;
`else
  // Low bits are discarded by design; keep them visibly consumed.
  logic unused_pc_lo;
  assign unused_pc_lo = ^redirect_pc_i[1:0];
  assign misalign     = 1'b0;
  assign redirect_tgt = {redirect_pc_i[ADDR_W-1:2], 2'b00};
`endif

  // A fault raised this cycle must already block the next fetch.
  assign en_eff = en_i && !fault_q && !misalign;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    data_d    = data_q;
    dpc_d     = dpc_q;
    fault_d   = fault_q;
    req_raw   = (state_q == REQ);
    rd_en_raw = 1'b0;

    if (redirect_i) begin
      pc_d = redirect_tgt;
      if (misalign) fault_d = 1'b1;
      unique case (state_q)
        IDLE, HOLD: state_d = en_eff ? REQ : IDLE;
        // A granted request still owes a response; drain it before reissuing.
        REQ:        state_d = mem_gnt_i    ? DRAIN : (misalign ? IDLE : REQ);
        WAIT:       state_d = mem_rvalid_i ? (misalign ? IDLE : REQ) : DRAIN;
        DRAIN:      state_d = DRAIN;
        default:    state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (en_eff) state_d = REQ;
        REQ:  if (mem_gnt_i) state_d = WAIT;
        WAIT: begin
          if (mem_rvalid_i) begin
            data_d  = mem_rdata_i;
            dpc_d   = pc_q;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (dec_ready_i) begin
            rd_en_raw = 1'b1;
            pc_d      = pc_q + ADDR_W'(PC_STEP);
            state_d   = en_eff ? REQ : IDLE;
          end
        end
        DRAIN: if (mem_rvalid_i) state_d = en_eff ? REQ : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      dpc_q   <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      dpc_q   <= dpc_d;
      fault_q <= fault_d;
    end
  end

  // Masked during reset so nothing is requested or consumed in the reset cycle.
  assign mem_req_o   = req_raw && !rst_i;
  assign dec_rd_en_o = rd_en_raw && !rst_i;
  assign mem_addr_o  = pc_q;
  assign dec_data_o  = data_q;
  assign dec_pc_o    = dpc_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle-latency memory responder.
// Latency: inputs applied at negedge, outputs sampled 1 ns later.
// Backpressure: dec_ready_i and grant driven per scenario.
module tb_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_rdata_i, dec_data_o, dec_pc_o, redirect_pc_i;
  logic        dec_ready_i, dec_rd_en_o, redirect_i, fault_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // memory model state
  logic        rv_pending = 1'b0;
  logic [31:0] rv_addr    = '0;
  logic        mem_const  = 1'b1;

  // observed outputs for the current cycle
  logic        o_req, o_rd, o_fault;
  logic [31:0] o_addr, o_data, o_pc;

  fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .dec_ready_i(dec_ready_i), .dec_rd_en_o(dec_rd_en_o),
    .dec_data_o(dec_data_o), .dec_pc_o(dec_pc_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock: drive memory inputs, sample outputs, cross the posedge.
  task automatic tick();
    logic        granted;
    logic [31:0] gaddr;
    mem_gnt_i    = mem_req_o;
    mem_rvalid_i = rv_pending;
    mem_rdata_i  = mem_const ? 32'h1300_0000 : (32'hA500_0000 | rv_addr);
    #1;
    o_req = mem_req_o; o_addr = mem_addr_o; o_rd = dec_rd_en_o;
    o_data = dec_data_o; o_pc = dec_pc_o; o_fault = fault_o;
    granted = mem_gnt_i && mem_req_o;
    gaddr   = mem_addr_o;
    @(negedge clk_i);
    rv_pending = granted;
    rv_addr    = gaddr;
  endtask

  // Reset, then one IDLE cycle with en_i=1 so the next tick is REQ at RESET_PC.
  task automatic restart();
    rst_i = 1'b1; en_i = 1'b1; dec_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b0; dec_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    tick(); tick();
    n_cmp++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", o_req); end
    n_cmp++; if (o_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b want 0", o_rd); end
    n_cmp++; if (o_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", o_fault); end
    n_cmp++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", o_data); end
    n_cmp++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", o_pc); end
  endtask

  task automatic test_stream();
    mem_const = 1'b1;
    restart();
    for (int c = 0; c < 9; c++) begin
      tick();
      n_cmp++; if (o_req !== (c % 3 == 0)) begin n_fail++; $display("FAIL stream_req c=%0d got %b", c, o_req); end
      n_cmp++; if (o_rd !== (c % 3 == 2)) begin n_fail++; $display("FAIL stream_rd c=%0d got %b", c, o_rd); end
      if (c % 3 == 0) begin
        n_cmp++; if (o_addr !== 32'((c / 3) * 4)) begin n_fail++; $display("FAIL stream_addr c=%0d got %h want %h", c, o_addr, (c / 3) * 4); end
      end
      if (c % 3 == 2) begin
        n_cmp++; if (o_data !== 32'h1300_0000) begin n_fail++; $display("FAIL stream_data c=%0d got %h want 13000000", c, o_data); end
        n_cmp++; if (o_pc !== 32'((c / 3) * 4)) begin n_fail++; $display("FAIL stream_pc c=%0d got %h want %h", c, o_pc, (c / 3) * 4); end
      end
    end
  endtask

  // Continues from test_stream: next fetch is at 0xC.
  task automatic test_stall();
    mem_const = 1'b0;
    tick();
    n_cmp++; if (o_addr !== 32'hC) begin n_fail++; $display("FAIL stall_addr got %h want c", o_addr); end
    tick();
    dec_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (o_rd !== 1'b0 || o_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold i=%0d rd=%b req=%b want 0 0", i, o_rd, o_req); end
      n_cmp++; if (o_data !== 32'hA500_000C || o_pc !== 32'hC) begin n_fail++; $display("FAIL stall_word i=%0d got %h@%h want a500000c@c", i, o_data, o_pc); end
    end
    dec_ready_i = 1'b1;
    tick();
    n_cmp++; if (o_rd !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", o_rd); end
    tick();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h10) begin n_fail++; $display("FAIL stall_next req=%b addr=%h want 1 10", o_req, o_addr); end
  endtask

  task automatic test_redirect_gnt();
    mem_const = 1'b0;
    restart();
    for (int i = 0; i < 6; i++) tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h8) begin n_fail++; $display("FAIL rg_req req=%b addr=%h want 1 8", o_req, o_addr); end
    redirect_i = 1'b0;
    tick();
    n_cmp++; if (o_rd !== 1'b0 || o_req !== 1'b0) begin n_fail++; $display("FAIL rg_drain rd=%b req=%b want 0 0", o_rd, o_req); end
    tick();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h100) begin n_fail++; $display("FAIL rg_target req=%b addr=%h want 1 100", o_req, o_addr); end
    tick();
    tick();
    n_cmp++; if (o_rd !== 1'b1 || o_pc !== 32'h100 || o_data !== 32'hA500_0100) begin n_fail++; $display("FAIL rg_word rd=%b %h@%h want 1 a5000100@100", o_rd, o_data, o_pc); end
  endtask

  task automatic test_redirect_hold();
    restart();
    tick(); tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    n_cmp++; if (o_rd !== 1'b0) begin n_fail++; $display("FAIL rh_nopulse got %b want 0", o_rd); end
    redirect_i = 1'b0;
    tick();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h200) begin n_fail++; $display("FAIL rh_target req=%b addr=%h want 1 200", o_req, o_addr); end
    tick(); tick();
    n_cmp++; if (o_rd !== 1'b1 || o_pc !== 32'h200) begin n_fail++; $display("FAIL rh_word rd=%b pc=%h want 1 200", o_rd, o_pc); end
  endtask

  task automatic test_redirect_wait();
    restart();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    tick();
    n_cmp++; if (o_rd !== 1'b0 || o_req !== 1'b0) begin n_fail++; $display("FAIL rw_wait rd=%b req=%b want 0 0", o_rd, o_req); end
    redirect_i = 1'b0;
    tick();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h40) begin n_fail++; $display("FAIL rw_target req=%b addr=%h want 1 40", o_req, o_addr); end
  endtask

  task automatic test_en_drop();
    restart();
    tick();
    en_i = 1'b0;
    tick(); tick();
    n_cmp++; if (o_rd !== 1'b1 || o_data !== 32'hA500_0000 || o_pc !== 32'h0) begin n_fail++; $display("FAIL en_word rd=%b %h@%h want 1 a5000000@0", o_rd, o_data, o_pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (o_req !== 1'b0 || o_rd !== 1'b0) begin n_fail++; $display("FAIL en_idle i=%0d req=%b rd=%b want 0 0", i, o_req, o_rd); end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    tick(); tick();
    dec_ready_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; en_i = 1'b0;
    tick();
    n_cmp++; if (o_req !== 1'b0 || o_rd !== 1'b0) begin n_fail++; $display("FAIL rm_ctrl req=%b rd=%b want 0 0", o_req, o_rd); end
    n_cmp++; if (o_data !== 32'h0 || o_pc !== 32'h0) begin n_fail++; $display("FAIL rm_word got %h@%h want 0@0", o_data, o_pc); end
  endtask

`ifdef FETCH_ALIGN_CHK_EN
  task automatic test_align();
    restart();
    tick(); tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    n_cmp++; if (o_rd !== 1'b0 || o_fault !== 1'b0) begin n_fail++; $display("FAIL al_cycle rd=%b fault=%b want 0 0", o_rd, o_fault); end
    redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (o_fault !== 1'b1 || o_req !== 1'b0) begin n_fail++; $display("FAIL al_sticky i=%0d fault=%b req=%b want 1 0", i, o_fault, o_req); end
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    n_cmp++; if (o_fault !== 1'b0) begin n_fail++; $display("FAIL al_clear got %b want 0", o_fault); end
  endtask
`else
  task automatic test_align();
    restart();
    tick(); tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    n_cmp++; if (o_rd !== 1'b0 || o_fault !== 1'b0) begin n_fail++; $display("FAIL al_cycle rd=%b fault=%b want 0 0", o_rd, o_fault); end
    redirect_i = 1'b0;
    tick();
    n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h100 || o_fault !== 1'b0) begin n_fail++; $display("FAIL al_force req=%b addr=%h fault=%b want 1 100 0", o_req, o_addr, o_fault); end
  endtask
`endif

  initial begin
    rst_i = 1'b1; en_i = 1'b0; dec_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk_i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_gnt();
    test_redirect_hold();
    test_redirect_wait();
    test_en_drop();
    test_reset_mid();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
